voq_rr_scheduler: RTL and testbench

VOQ_RR_SCHEDULER -- requirements
Module: voq_rr_scheduler

---
 rtl/voq_rr_scheduler.sv | 165 ++++++++++++++++
 tb/tb_voq_rr_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/voq_rr_scheduler.sv
// Packet-locked round-robin scheduler for VOQ head-of-line requests.
// Optional watchdog release is compiled in with VOQ_SCHED_WATCHDOG_EN.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

module voq_rr_scheduler #(
  parameter int PORT_NUB  = `PORT_NUB_TOTAL,
  parameter int WIDTH_SEL = $clog2(PORT_NUB),
  parameter int WDT_MAX   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PORT_NUB-1:0]  req_in,
  input  logic [PORT_NUB-1:0]  eop_in,
  input  logic                 voq_full_in,
  output logic [PORT_NUB-1:0]  grant_out,
  output logic [WIDTH_SEL-1:0] grant_idx,
  output logic                 grant_valid,
  output logic                 xfer_out,
  output logic                 wdt_err
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH_SEL-1:0] rr_ptr_reg, rr_ptr_next;
  logic [PORT_NUB-1:0]  grant_reg, grant_next;
  logic [WIDTH_SEL-1:0] idx_reg, idx_next;
  logic                 valid_reg, valid_next;

  logic [WIDTH_SEL-1:0] ptr_inc;
  logic [WIDTH_SEL-1:0] arb_ptr;
  logic [WIDTH_SEL-1:0] pick;
  logic                 found;
  logic [PORT_NUB-1:0]  pick_onehot;
  logic                 eop_xfer;

  assign xfer_out  = valid_reg & req_in[idx_reg] & ~voq_full_in;
  assign eop_xfer  = xfer_out & eop_in[idx_reg];
  assign ptr_inc   = (int'(idx_reg) == PORT_NUB-1) ? '0 : idx_reg + 1'b1;
  // A completing packet arbitrates from the advanced pointer in the same cycle.
  assign arb_ptr   = eop_xfer ? ptr_inc : rr_ptr_reg;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < PORT_NUB; k++) begin
      int cand;
      cand = int'(arb_ptr) + k;
      if (cand >= PORT_NUB) cand = cand - PORT_NUB;
      if (!found && req_in[cand]) begin
        found = 1'b1;
        pick  = WIDTH_SEL'(cand);
      end
    end
  end

  for (genvar gi = 0; gi < PORT_NUB; gi++) begin : g_onehot
    assign pick_onehot[gi] = (int'(pick) == gi);
  end

`ifdef VOQ_SCHED_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDT_MAX + 1);
  logic [CNT_W-1:0] wdt_cnt_reg, wdt_cnt_next;
  logic             wdt_err_reg, wdt_err_next;
`endif

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    idx_next    = idx_reg;
    valid_next  = valid_reg;
`ifdef VOQ_SCHED_WATCHDOG_EN
    wdt_cnt_next = wdt_cnt_reg;
    wdt_err_next = 1'b0;
`endif
    // A full downstream freezes the whole scheduler.
    if (!voq_full_in) begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_next = HOLD;
            grant_next = pick_onehot;
            idx_next   = pick;
            valid_next = 1'b1;
          end
        end
        HOLD: begin
          if (eop_xfer) begin
            rr_ptr_next = ptr_inc;
`ifdef VOQ_SCHED_WATCHDOG_EN
            wdt_cnt_next = '0;
`endif
            if (found) begin
              grant_next = pick_onehot;
              idx_next   = pick;
            end else begin
              state_next = IDLE;
              grant_next = '0;
              idx_next   = '0;
              valid_next = 1'b0;
            end
          end else if (xfer_out) begin
`ifdef VOQ_SCHED_WATCHDOG_EN
            wdt_cnt_next = '0;
`endif
          end else begin
`ifdef VOQ_SCHED_WATCHDOG_EN
            if (int'(wdt_cnt_reg) == WDT_MAX - 1) begin
              rr_ptr_next  = ptr_inc;
              wdt_cnt_next = '0;
              wdt_err_next = 1'b1;
              state_next   = IDLE;
              grant_next   = '0;
              idx_next     = '0;
              valid_next   = 1'b0;
            end else begin
              wdt_cnt_next = wdt_cnt_reg + 1'b1;
            end
`endif
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      idx_reg    <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      idx_reg    <= idx_next;
      valid_reg  <= valid_next;
    end
  end

`ifdef VOQ_SCHED_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt_reg <= '0;
      wdt_err_reg <= 1'b0;
    end else begin
      wdt_cnt_reg <= wdt_cnt_next;
      wdt_err_reg <= wdt_err_next;
    end
  end
  assign wdt_err = wdt_err_reg;
`else
  assign wdt_err = 1'b0;
`endif

  assign grant_out   = grant_reg;
  assign grant_idx   = idx_reg;
  assign grant_valid = valid_reg;

endmodule

// File: tb/tb_voq_rr_scheduler.sv
// Randomized scoreboard bench for voq_rr_scheduler against a packet-level model.
// Watchdog scenario is exercised when VOQ_SCHED_WATCHDOG_EN is defined.
module tb_voq_rr_scheduler;

  localparam int N   = 4;
  localparam int WDT = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_in = '0;
  logic [N-1:0] eop_in = '0;
  logic         voq_full_in = 1'b0;
  logic [N-1:0] grant_out;
  logic [1:0]   grant_idx;
  logic         grant_valid;
  logic         xfer_out;
  logic         wdt_err;

  voq_rr_scheduler #(.PORT_NUB(N), .WIDTH_SEL(2), .WDT_MAX(WDT)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .eop_in(eop_in),
    .voq_full_in(voq_full_in), .grant_out(grant_out), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .xfer_out(xfer_out), .wdt_err(wdt_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [1:0]   idx;
    logic         vld;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  logic xfer_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Model state: granted port (-1 = none), round-robin pointer, idle-hold count.
  int   m_gnt = -1;
  int   m_ptr = 0;
  int   m_cnt = 0;
  logic m_err = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic int arb(input logic [N-1:0] r, input int p);
    for (int off = 0; off < N; off++)
      if (r[(p + off) % N]) return (p + off) % N;
    return -1;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt = (m_gnt >= 0) ? N'(1 << m_gnt) : '0;
    e.idx = (m_gnt >= 0) ? 2'(m_gnt) : 2'd0;
    e.vld = (m_gnt >= 0);
    e.err = m_err;
    return e;
  endfunction

  // One clock of stimulus: drive at negedge, advance the model, push expectations.
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] e, input logic f);
    logic x;
    @(negedge clk);
    cyc++;
    rst_n = 1'b1; req_in = r; eop_in = e; voq_full_in = f;
    x = (m_gnt >= 0) && r[m_gnt] && !f;
    xfer_q.push_back(x);
    m_err = 1'b0;
    if (!f) begin
      if (m_gnt < 0) begin
        m_gnt = arb(r, m_ptr);
      end else if (x && e[m_gnt]) begin
        m_ptr = (m_gnt + 1) % N;
        m_cnt = 0;
        m_gnt = arb(r, m_ptr);
      end else if (x) begin
        m_cnt = 0;
      end else begin
`ifdef VOQ_SCHED_WATCHDOG_EN
        m_cnt++;
        if (m_cnt == WDT) begin
          m_ptr = (m_gnt + 1) % N;
          m_gnt = -1;
          m_cnt = 0;
          m_err = 1'b1;
        end
`endif
      end
    end
    exp_q.push_back(model_out());
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      rst_n = 1'b0; req_in = '0; eop_in = '0; voq_full_in = 1'b0;
      m_gnt = -1; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
      #1;
      chk("async_reset_grant", int'(grant_out), 0);
      xfer_q.push_back(1'b0);
      exp_q.push_back(model_out());
    end
  endtask

  // Registered-output monitor.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("grant_out", int'(grant_out), int'(e.gnt));
        chk("grant_idx", int'(grant_idx), int'(e.idx));
        chk("grant_valid", int'(grant_valid), int'(e.vld));
        chk("wdt_err", int'(wdt_err), int'(e.err));
        chk("onehot0", int'($onehot0(grant_out)), 1);
      end
    end
  end

  // Combinational strobe monitor.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (xfer_q.size() > 0) begin
        logic x;
        x = xfer_q.pop_front();
        chk("xfer_out", int'(xfer_out), int'(x));
      end
    end
  end

  initial begin
    reset_cycles(2);

    // Two requesters: port 1 first, then port 3 after its EOP.
    drive(4'b1010, 4'b0000, 1'b0);
    drive(4'b1010, 4'b0010, 1'b0);
    drive(4'b1000, 4'b1000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // All ports, single-beat packets: back-to-back rotation.
    for (int i = 0; i < 6; i++) drive(4'b1111, 4'b1111, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // Port 2, five-beat packet with a three-cycle stall in the middle.
    reset_cycles(1);
    drive(4'b0100, 4'b0000, 1'b0);
    drive(4'b0100, 4'b0000, 1'b0);
    drive(4'b0100, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) drive(4'b0100, 4'b0100, 1'b1);
    drive(4'b0100, 4'b0000, 1'b0);
    drive(4'b0100, 4'b0000, 1'b0);
    drive(4'b0100, 4'b0100, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // Port 0 holds while port 3 arrives; gap beat included.
    reset_cycles(1);
    drive(4'b0001, 4'b0000, 1'b0);
    drive(4'b1001, 4'b1000, 1'b0);
    drive(4'b1000, 4'b1000, 1'b0);
    drive(4'b1001, 4'b0001, 1'b0);
    drive(4'b1000, 4'b1000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // Reset mid-packet on port 2, then arbitration restarts from port 0.
    reset_cycles(1);
    drive(4'b0100, 4'b0000, 1'b0);
    drive(4'b0100, 4'b0000, 1'b0);
    reset_cycles(1);
    drive(4'b0110, 4'b0000, 1'b0);
    drive(4'b0110, 4'b0010, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

`ifdef VOQ_SCHED_WATCHDOG_EN
    // Port 1 granted then goes silent until the watchdog releases it.
    reset_cycles(1);
    drive(4'b0010, 4'b0000, 1'b0);
    drive(4'b0010, 4'b0000, 1'b0);
    for (int i = 0; i < WDT + 2; i++) drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0111, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
`endif

    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r, e;
      logic f;
      if ($urandom_range(0, 499) == 0) reset_cycles($urandom_range(1, 2));
      r = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b1111;
      e = '0;
      for (int b = 0; b < N; b++) e[b] = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 7) == 0);
      drive(r, e, f);
    end

    drive(4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0 || xfer_q.size() != 0)
      chk("scoreboard_drain", exp_q.size() + xfer_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
